// File: rtl/assert_logger_pkg.sv
// Shared types and default sizing for the assertion event logger.
// Imported by the FIFO and the top level.
package assert_logger_pkg;

    localparam int unsigned CNT_W_DEF   = 16;
    localparam int unsigned DEPTH_DEF   = 4;
    localparam int unsigned MAX_RUN_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_FAIL_RUN,
        ST_ALARM
    } state_t;

endpackage

// File: rtl/assert_log_fifo.sv
// Synchronous failure-timestamp FIFO.
// A pop frees a slot for a same-cycle push when full.
module assert_log_fifo
    import assert_logger_pkg::*;
#(
    parameter int unsigned W     = CNT_W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full,
    output logic         drop
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/assert_event_logger.sv
// On-chip consumer of the a && b check: counters, run FSM,
// sticky alarm and a timestamp log for a valid/ready reader.
module assert_event_logger
    import assert_logger_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned MAX_RUN = MAX_RUN_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             chk_en,
    input  logic             chk_a,
    input  logic             chk_b,
    input  logic             clr,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             fail_sticky,
    output logic             alarm,
    output logic             log_valid,
    output logic [CNT_W-1:0] log_data,
    input  logic             log_ready,
    output logic             log_ovf
);

    localparam int unsigned     RUN_W   = $clog2(MAX_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RUN);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    state_t           state;
    state_t           state_n;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_n;
    logic             fail;
    logic             pass;
    logic             empty;
    logic             full;
    logic             drop;

    assign fail  = chk_en && !(chk_a && chk_b);
    assign pass  = chk_en && chk_a && chk_b;
    assign alarm = (state == ST_ALARM);

    always_comb begin
        state_n = state;
        run_n   = run;
        unique case (state)
            ST_IDLE, ST_PASS: begin
                if (fail) begin
                    run_n   = RUN_ONE;
                    state_n = (RUN_MAX == RUN_ONE) ? ST_ALARM : ST_FAIL_RUN;
                end else if (pass) begin
                    state_n = ST_PASS;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_FAIL_RUN: begin
                if (fail) begin
                    run_n = run + 1'b1;
                    if (run_n == RUN_MAX) state_n = ST_ALARM;
                end else if (pass) begin
                    run_n   = '0;
                    state_n = ST_PASS;
                end else begin
                    run_n   = '0;
                    state_n = ST_IDLE;
                end
            end
            ST_ALARM: begin
                state_n = ST_ALARM;
            end
            default: begin
                run_n   = '0;
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            run   <= '0;
        end else if (clr) begin
            state <= ST_IDLE;
            run   <= '0;
        end else begin
            state <= state_n;
            run   <= run_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt     <= '0;
            fail_cnt    <= '0;
            fail_sticky <= 1'b0;
            log_ovf     <= 1'b0;
        end else if (clr) begin
            cyc_cnt     <= '0;
            fail_cnt    <= '0;
            fail_sticky <= 1'b0;
            log_ovf     <= 1'b0;
        end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
            if (fail) begin
                fail_sticky <= 1'b1;
                if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
            end
            if (drop) log_ovf <= 1'b1;
        end
    end

    // Timestamp is the cycle count before this edge's increment.
    assert_log_fifo #(
        .W     (CNT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .push      (fail),
        .push_data (cyc_cnt),
        .pop       (log_ready),
        .head      (log_data),
        .empty     (empty),
        .full      (full),
        .drop      (drop)
    );

    assign log_valid = !empty;

endmodule

// File: tb/tb_assert_event_logger.sv
// Scenario bench for assert_event_logger with a timestamp scoreboard.
// Expected timestamps are queued at stimulus time and compared on pop.
module tb_assert_event_logger;

    localparam int CNT_W   = 16;
    localparam int DEPTH   = 4;
    localparam int MAX_RUN = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             chk_en;
    logic             chk_a;
    logic             chk_b;
    logic             clr;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic             fail_sticky;
    logic             alarm;
    logic             log_valid;
    logic [CNT_W-1:0] log_data;
    logic             log_ready;
    logic             log_ovf;

    int n_pass  = 0;
    int n_total = 0;

    logic [CNT_W-1:0] exp_q[$];
    logic [CNT_W-1:0] m_cyc;
    int               pops;

    always #5 clk = ~clk;

    assert_event_logger #(
        .CNT_W   (CNT_W),
        .DEPTH   (DEPTH),
        .MAX_RUN (MAX_RUN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .chk_en      (chk_en),
        .chk_a       (chk_a),
        .chk_b       (chk_b),
        .clr         (clr),
        .cyc_cnt     (cyc_cnt),
        .fail_cnt    (fail_cnt),
        .fail_sticky (fail_sticky),
        .alarm       (alarm),
        .log_valid   (log_valid),
        .log_data    (log_data),
        .log_ready   (log_ready),
        .log_ovf     (log_ovf)
    );

    task automatic m_reset();
        exp_q.delete();
        m_cyc = '0;
    endtask

    // One clock: scoreboard pop/compare, model push, then the edge.
    task automatic tick();
        logic f;
        f = chk_en && !(chk_a && chk_b);
        if (!rst_n || clr) begin
            m_reset();
        end else begin
            if (log_ready && exp_q.size() > 0) begin
                n_total++;
                if (log_data !== exp_q[0])
                    $display("FAIL pop_data: got %0d want %0d", log_data, exp_q[0]);
                else
                    n_pass++;
                void'(exp_q.pop_front());
                pops++;
            end
            if (f && exp_q.size() < DEPTH) exp_q.push_back(m_cyc);
            m_cyc = m_cyc + 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; chk_en = 0; chk_a = 0; chk_b = 0;
        clr = 0; log_ready = 0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({cyc_cnt, fail_cnt, log_data} !== '0)
            $display("FAIL reset_cnt: got %0h/%0h/%0h want 0", cyc_cnt, fail_cnt, log_data);
        else n_pass++;
        n_total++;
        if ({fail_sticky, alarm, log_valid, log_ovf} !== 4'b0)
            $display("FAIL reset_flags: got %b want 0000",
                     {fail_sticky, alarm, log_valid, log_ovf});
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_pass_run();
        chk_en = 1; chk_a = 1; chk_b = 1;
        repeat (10) tick();
        n_total++;
        if (cyc_cnt !== 16'd10) $display("FAIL pass_cyc: got %0d want 10", cyc_cnt);
        else n_pass++;
        n_total++;
        if ({fail_cnt, log_valid, alarm} !== '0)
            $display("FAIL pass_clean: got %0d %b %b want 0 0 0", fail_cnt, log_valid, alarm);
        else n_pass++;
    endtask

    task automatic test_single_fail();
        do_clr();
        tick();
        chk_b = 0; tick();
        chk_b = 1; tick();
        n_total++;
        if (fail_cnt !== 16'd1 || fail_sticky !== 1'b1)
            $display("FAIL single_cnt: got %0d %b want 1 1", fail_cnt, fail_sticky);
        else n_pass++;
        n_total++;
        if (log_valid !== 1'b1 || log_data !== 16'd1 || alarm !== 1'b0)
            $display("FAIL single_log: got %b %0d %b want 1 1 0", log_valid, log_data, alarm);
        else n_pass++;
        log_ready = 1; tick(); log_ready = 0;
        n_total++;
        if (log_valid !== 1'b0) $display("FAIL single_drain: got %b want 0", log_valid);
        else n_pass++;
    endtask

    task automatic test_runs();
        do_clr();
        tick(); tick();
        chk_a = 0; tick(); tick();
        chk_a = 1; tick();
        n_total++;
        if (fail_cnt !== 16'd2 || alarm !== 1'b0)
            $display("FAIL run2: got %0d %b want 2 0", fail_cnt, alarm);
        else n_pass++;
        chk_a = 0; tick(); tick();
        n_total++;
        if (alarm !== 1'b0) $display("FAIL run3_early: got %b want 0", alarm);
        else n_pass++;
        chk_a = 1;
        log_ready = 1;
        chk_a = 0; tick(); chk_a = 1;
        n_total++;
        if (alarm !== 1'b1) $display("FAIL run3_alarm: got %b want 1", alarm);
        else n_pass++;
        repeat (3) tick();
        n_total++;
        if (alarm !== 1'b1 || fail_cnt !== 16'd5)
            $display("FAIL alarm_sticky: got %b %0d want 1 5", alarm, fail_cnt);
        else n_pass++;
        log_ready = 0;
    endtask

    task automatic test_overflow();
        do_clr();
        log_ready = 0;
        chk_a = 0;
        repeat (6) tick();
        chk_a = 1;
        n_total++;
        if (fail_cnt !== 16'd6 || log_ovf !== 1'b1)
            $display("FAIL ovf_flag: got %0d %b want 6 1", fail_cnt, log_ovf);
        else n_pass++;
        n_total++;
        if (log_valid !== 1'b1 || log_data !== 16'd0)
            $display("FAIL ovf_head: got %b %0d want 1 0", log_valid, log_data);
        else n_pass++;
        log_ready = 1;
        pops = 0;
        for (int i = 0; i < 10 && log_valid; i++) tick();
        log_ready = 0;
        n_total++;
        if (pops !== DEPTH || log_valid !== 1'b0)
            $display("FAIL ovf_drain: got %0d pops valid=%b want %0d 0", pops, log_valid, DEPTH);
        else n_pass++;
    endtask

    task automatic test_full_pop();
        do_clr();
        chk_a = 0;
        repeat (DEPTH) tick();
        log_ready = 1;
        tick();
        chk_a = 1;
        log_ready = 0;
        tick();
        n_total++;
        if (log_ovf !== 1'b0 || fail_cnt !== 16'd5)
            $display("FAIL fullpop_ovf: got %b %0d want 0 5", log_ovf, fail_cnt);
        else n_pass++;
        log_ready = 1;
        pops = 0;
        for (int i = 0; i < 10 && log_valid; i++) tick();
        log_ready = 0;
        n_total++;
        if (pops !== DEPTH || exp_q.size() != 0)
            $display("FAIL fullpop_count: got %0d pops want %0d", pops, DEPTH);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        do_clr();
        chk_a = 0; tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({cyc_cnt, fail_cnt, log_data, fail_sticky, alarm, log_valid, log_ovf} !== '0)
            $display("FAIL async_rst: got %0d %0d %0d %b%b%b%b want all 0", cyc_cnt,
                     fail_cnt, log_data, fail_sticky, alarm, log_valid, log_ovf);
        else n_pass++;
        tick();
        rst_n = 1'b1;
        m_reset();
        tick(); tick();
        n_total++;
        if (alarm !== 1'b0 || fail_cnt !== 16'd2)
            $display("FAIL rst_run_cleared: got %b %0d want 0 2", alarm, fail_cnt);
        else n_pass++;
        chk_a = 1;
    endtask

    task automatic test_clr_with_fail();
        chk_a = 0; tick();
        clr = 1'b1; tick(); clr = 1'b0;
        chk_a = 1;
        n_total++;
        if ({cyc_cnt, fail_cnt, log_data, fail_sticky, alarm, log_valid, log_ovf} !== '0)
            $display("FAIL clr_fail: got %0d %0d %0d %b%b%b%b want all 0", cyc_cnt,
                     fail_cnt, log_data, fail_sticky, alarm, log_valid, log_ovf);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_pass_run();
        test_single_fail();
        test_runs();
        test_overflow();
        test_full_pop();
        test_reset_mid_run();
        test_clr_with_fail();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
